// File: rtl/core_pkg.sv
// Shared types and constants for the custom-ISA core: PC width, reset address,
// sequencer state encoding and the PC type.
package core_pkg;

  localparam int PC_WIDTH   = 10;
  localparam int START_ADDR = 0;

  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

  typedef logic [PC_WIDTH-1:0] pc_t;

endpackage

// File: rtl/pc_sequencer.sv
// Program counter and run-control (Start/Done handshake, wrap fault) sitting after the branch-target LUT.
// Optional macro PC_CYCLE_COUNT_EN builds a saturating RUN-cycle counter on CycleCnt; otherwise CycleCnt is 0.
module pc_sequencer #(
  parameter int PC_width   = core_pkg::PC_WIDTH,
  parameter int START_ADDR = core_pkg::START_ADDR
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic                Halt,
  input  logic                BranchAbs,
  input  logic                BranchRel,
  input  logic                Taken,
  input  logic [PC_width-1:0] Target,
  output logic [PC_width-1:0] ProgCtr,
  output logic                Running,
  output logic                Done,
  output logic                Fault,
  output logic [15:0]         CycleCnt
);
  import core_pkg::*;

  localparam logic [PC_width-1:0] start_pc = PC_width'(START_ADDR);
  localparam logic [PC_width-1:0] last_pc  = '1;

  seq_state_t          state, next_state;
  logic [PC_width-1:0] pc_q, pc_d;
  logic                fault_q, fault_d;
  logic                running_q, done_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      pc_q      <= start_pc;
      fault_q   <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= next_state;
      pc_q      <= pc_d;
      fault_q   <= fault_d;
      running_q <= (next_state == RUN);
      done_q    <= (next_state == DONE);
    end
  end

  // Relative offsets are as wide as the PC, so plain addition is the sign-extended modulo add.
  always_comb begin
    next_state = state;
    pc_d       = pc_q;
    fault_d    = fault_q;
    unique case (state)
      IDLE: begin
        if (Start) begin
          next_state = RUN;
          pc_d       = start_pc;
          fault_d    = 1'b0;
        end
      end
      RUN: begin
        if (Halt) begin
          next_state = DONE;
        end else if (BranchAbs && Taken) begin
          pc_d = Target;
        end else if (BranchRel && Taken) begin
          pc_d = pc_q + Target;
        end else if (pc_q == last_pc) begin
          next_state = DONE;
          fault_d    = 1'b1;
        end else begin
          pc_d = pc_q + PC_width'(1);
        end
      end
      DONE: begin
        if (!Start) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign ProgCtr = pc_q;
  assign Running = running_q;
  assign Done    = done_q;
  assign Fault   = fault_q;

`ifdef PC_CYCLE_COUNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else if (state == IDLE && next_state == RUN) begin
      cnt_q <= '0;
    end else if (state == RUN && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign CycleCnt = cnt_q;
`else
  assign CycleCnt = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios plus random stimulus, checked
// against a behavioural model; honours PC_CYCLE_COUNT_EN for the CycleCnt expectation.
module tb_pc_sequencer;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  typedef struct {
    logic [9:0]  pc;
    logic        running;
    logic        done;
    logic        fault;
    logic [15:0] cnt;
    string       tag;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        Halt = 1'b0;
  logic        BranchAbs = 1'b0;
  logic        BranchRel = 1'b0;
  logic        Taken = 1'b0;
  logic [9:0]  Target = '0;
  logic [9:0]  ProgCtr;
  logic        Running;
  logic        Done;
  logic        Fault;
  logic [15:0] CycleCnt;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  int   mState = M_IDLE;
  int   mPc = 0;
  int   mCnt = 0;
  bit   mFault = 1'b0;

  pc_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt),
    .BranchAbs(BranchAbs), .BranchRel(BranchRel), .Taken(Taken), .Target(Target),
    .ProgCtr(ProgCtr), .Running(Running), .Done(Done), .Fault(Fault), .CycleCnt(CycleCnt)
  );

  always #5 Clk = ~Clk;

  // Reference behaviour: one clock edge of the sequencer expressed as plain integer arithmetic.
  task automatic modelStep(input bit rst, st, h, ba, br, tk, input int tgt);
    int off;
    if (rst) begin
      mState = M_IDLE; mPc = 0; mFault = 0; mCnt = 0;
    end else if (mState == M_IDLE) begin
      if (st) begin
        mState = M_RUN; mPc = 0; mFault = 0; mCnt = 0;
      end
    end else if (mState == M_RUN) begin
      mCnt = (mCnt < 65535) ? mCnt + 1 : 65535;
      if (h) begin
        mState = M_DONE;
      end else if (ba && tk) begin
        mPc = tgt;
      end else if (br && tk) begin
        off = (tgt >= 512) ? tgt - 1024 : tgt;
        mPc = (mPc + off + 1024) % 1024;
      end else if (mPc == 1023) begin
        mState = M_DONE; mFault = 1;
      end else begin
        mPc = mPc + 1;
      end
    end else begin
      if (!st) mState = M_IDLE;
    end
  endtask

  task automatic applyStimulus(input string tag, input bit rst, st, h, ba, br, tk, input int tgt);
    exp_t e;
    @(negedge Clk);
    Reset = rst; Start = st; Halt = h; BranchAbs = ba; BranchRel = br; Taken = tk;
    Target = tgt[9:0];
    modelStep(rst, st, h, ba, br, tk, tgt);
    e.pc = mPc[9:0];
    e.running = (mState == M_RUN);
    e.done = (mState == M_DONE);
    e.fault = mFault;
`ifdef PC_CYCLE_COUNT_EN
    e.cnt = mCnt[15:0];
`else
    e.cnt = 16'd0;
`endif
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    vectors++;
    if (ProgCtr !== e.pc || Running !== e.running || Done !== e.done ||
        Fault !== e.fault || CycleCnt !== e.cnt) begin
      miscompares++;
      $display("[TB] FAIL %s: got pc=%h run=%b done=%b fault=%b cnt=%0d, expected pc=%h run=%b done=%b fault=%b cnt=%0d",
               e.tag, ProgCtr, Running, Done, Fault, CycleCnt,
               e.pc, e.running, e.done, e.fault, e.cnt);
    end
  endtask

  // Monitor: every edge the DUT presents new state, compare it against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    int drain;
    applyStimulus("reset", 1, 0, 0, 0, 0, 0, 0);
    applyStimulus("idle_after_reset", 0, 0, 0, 0, 0, 0, 0);

    applyStimulus("start_t1", 0, 1, 0, 0, 0, 0, 0);
    applyStimulus("abs_to_012", 0, 1, 0, 1, 0, 1, 'h012);
    applyStimulus("reset_midrun", 1, 1, 0, 0, 0, 0, 0);
    applyStimulus("idle_t1", 0, 0, 0, 0, 0, 0, 0);

    applyStimulus("start_t2", 0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) applyStimulus("seq_step", 0, 1, 0, 0, 0, 0, 0);
    applyStimulus("halt_at_4", 0, 1, 1, 0, 0, 0, 0);
    applyStimulus("done_hold_a", 0, 1, 0, 0, 0, 0, 0);
    applyStimulus("done_hold_b", 0, 1, 1, 1, 0, 1, 'h100);
    applyStimulus("done_to_idle", 0, 0, 0, 0, 0, 0, 0);

    applyStimulus("start_t3", 0, 1, 0, 0, 0, 0, 0);
    applyStimulus("abs_to_010", 0, 1, 0, 1, 0, 1, 'h010);
    applyStimulus("abs_taken_034", 0, 1, 0, 1, 0, 1, 'h034);
    applyStimulus("abs_to_010b", 0, 1, 0, 1, 0, 1, 'h010);
    applyStimulus("abs_not_taken", 0, 1, 0, 1, 0, 0, 'h034);

    applyStimulus("abs_to_008", 0, 1, 0, 1, 0, 1, 'h008);
    applyStimulus("rel_minus4", 0, 1, 0, 0, 1, 1, 'h3FC);
    applyStimulus("abs_to_002", 0, 1, 0, 1, 0, 1, 'h002);
    applyStimulus("rel_cross_zero", 0, 1, 0, 0, 1, 1, 'h3FC);

    applyStimulus("step_to_3ff", 0, 1, 0, 0, 0, 0, 0);
    applyStimulus("wrap_fault", 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus("no_restart", 0, 1, 0, 0, 0, 0, 0);
    applyStimulus("drop_start", 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("restart_clears", 0, 1, 0, 0, 0, 0, 0);

    applyStimulus("abs_to_020", 0, 1, 0, 1, 0, 1, 'h020);
    applyStimulus("halt_beats_abs", 0, 1, 1, 1, 0, 1, 'h155);
    applyStimulus("drop_start_t6", 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("start_t6", 0, 1, 0, 0, 0, 0, 0);
    applyStimulus("abs_beats_rel", 0, 1, 0, 1, 1, 1, 'h055);

    for (int i = 0; i < 800; i++) begin
      bit rst, st, h, ba, br, tk;
      int tgt;
      rst = ($urandom_range(0, 63) == 0);
      st  = ($urandom_range(0, 7) != 0);
      h   = ($urandom_range(0, 15) == 0);
      ba  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 3) == 0);
      tk  = $urandom_range(0, 1) == 1;
      tgt = $urandom_range(0, 1023);
      if ($urandom_range(0, 3) == 0) tgt = 1018 + $urandom_range(0, 5);
      applyStimulus("random", rst, st, h, ba, br, tk, tgt);
    end

    applyStimulus("final_reset", 1, 0, 0, 0, 0, 0, 0);

    drain = 0;
    while (sb.size() > 0 && drain < 8) begin
      @(posedge Clk);
      #2;
      drain++;
    end
    if (sb.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
